// File: rtl/lab3_f_sweep_ctrl.sv
// lab3_f_sweep_ctrl: exhaustive sweep sequencer for the 4-input lab3 f-function.
// It drives {w,x,y,z}=0..15 in order and holds each vector SETTLE_CYCLES+1 cycles.
// On the last cycle of each vector it samples f_in and compares it with the expected table.
// Ports:
//   clk/rst          clock; asynchronous active-high reset
//   start, expected  start request (IDLE only); expected table, captured when start is accepted
//   f_in             output of the function under test
//   w,x,y,z          registered vector drive (w = MSB)
//   busy, done       sweep in progress; one-cycle pulse when the sweep ends
//   pass, truth, mismatch, err_count, fail_idx   results, held until the next start
// Option: define LAB3_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module lab3_f_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        CL2947MP_clk,
  input  logic        CL2947MP_rst,
  input  logic        CL2947MP_start,
  input  logic [15:0] CL2947MP_expected,
  input  logic        CL2947MP_f_in,
  output logic        CL2947MP_w,
  output logic        CL2947MP_x,
  output logic        CL2947MP_y,
  output logic        CL2947MP_z,
  output logic        CL2947MP_busy,
  output logic        CL2947MP_done,
  output logic        CL2947MP_pass,
  output logic [15:0] CL2947MP_truth,
  output logic [15:0] CL2947MP_mismatch,
  output logic [4:0]  CL2947MP_err_count,
  output logic [3:0]  CL2947MP_fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] truth_q, truth_d;
  logic [15:0] mism_q, mism_d;
  logic [4:0]  errc_q, errc_d;
  logic [3:0]  fidx_q, fidx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        miss;
  logic        halt;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    truth_d = truth_q;
    mism_d  = mism_q;
    errc_d  = errc_q;
    fidx_d  = fidx_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    miss    = CL2947MP_f_in ^ exp_q[idx_q];
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
    halt    = (idx_q == 4'hF) || miss;
`else
    halt    = (idx_q == 4'hF);
`endif
    unique case (state_q)
      IDLE: begin
        if (CL2947MP_start) begin
          state_d = RUN;
          exp_d   = CL2947MP_expected;
          truth_d = 16'h0000;
          mism_d  = 16'h0000;
          errc_d  = 5'd0;
          fidx_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == SETTLE) begin
          truth_d[idx_q] = CL2947MP_f_in;
          mism_d[idx_q]  = miss;
          if (miss) begin
            errc_d = errc_q + 5'd1;
            // err_count still zero means this is the first failure
            if (errc_q == 5'd0) begin
              fidx_d = idx_q;
            end
          end
          if (halt) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (errc_d == 5'd0);
          end else begin
            idx_d = idx_q + 4'd1;
            cnt_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CL2947MP_clk or posedge CL2947MP_rst) begin
    if (CL2947MP_rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'h0000;
      truth_q <= 16'h0000;
      mism_q  <= 16'h0000;
      errc_q  <= 5'd0;
      fidx_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      truth_q <= truth_d;
      mism_q  <= mism_d;
      errc_q  <= errc_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} = idx_q;
  assign CL2947MP_busy      = busy_q;
  assign CL2947MP_done      = done_q;
  assign CL2947MP_pass      = pass_q;
  assign CL2947MP_truth     = truth_q;
  assign CL2947MP_mismatch  = mism_q;
  assign CL2947MP_err_count = errc_q;
  assign CL2947MP_fail_idx  = fidx_q;

endmodule

// File: tb/tb_lab3_f_sweep_ctrl.sv
// tb_lab3_f_sweep_ctrl: bench for the lab3 f-function sweep sequencer.
// The function under test is modelled as a lookup table indexed by the driven vector.
module tb_lab3_f_sweep_ctrl;

  localparam int S = 2;
  localparam int VP = S + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] expected;
  logic        f_in;
  logic        w, x, y, z;
  logic        busy, done, pass;
  logic [15:0] truth, mism;
  logic [4:0]  errc;
  logic [3:0]  fidx;
  logic [3:0]  vec;
  logic [15:0] tbl;
  logic        noise_on, noise_bit;

  logic        start0;
  logic [15:0] expected0;
  logic        f0_in;
  logic        w0, x0, y0, z0;
  logic        busy0, done0, pass0;
  logic [15:0] truth0, mism0;
  logic [4:0]  errc0;
  logic [3:0]  fidx0;
  logic [3:0]  vec0;
  logic [15:0] tbl0;

  assign vec  = {w, x, y, z};
  assign vec0 = {w0, x0, y0, z0};
  always_comb f_in  = noise_on ? noise_bit : tbl[vec];
  always_comb f0_in = tbl0[vec0];

  lab3_f_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst),
    .CL2947MP_start(start), .CL2947MP_expected(expected),
    .CL2947MP_f_in(f_in),
    .CL2947MP_w(w), .CL2947MP_x(x), .CL2947MP_y(y), .CL2947MP_z(z),
    .CL2947MP_busy(busy), .CL2947MP_done(done), .CL2947MP_pass(pass),
    .CL2947MP_truth(truth), .CL2947MP_mismatch(mism),
    .CL2947MP_err_count(errc), .CL2947MP_fail_idx(fidx)
  );

  lab3_f_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst),
    .CL2947MP_start(start0), .CL2947MP_expected(expected0),
    .CL2947MP_f_in(f0_in),
    .CL2947MP_w(w0), .CL2947MP_x(x0), .CL2947MP_y(y0), .CL2947MP_z(z0),
    .CL2947MP_busy(busy0), .CL2947MP_done(done0), .CL2947MP_pass(pass0),
    .CL2947MP_truth(truth0), .CL2947MP_mismatch(mism0),
    .CL2947MP_err_count(errc0), .CL2947MP_fail_idx(fidx0)
  );

  typedef struct {
    logic [15:0] tbl;
    logic [15:0] expv;
    bit          noise;
    logic [15:0] truth;
    logic [15:0] mism;
    logic [4:0]  errc;
    logic [3:0]  fidx;
    logic        pass;
    int          done_at;
  } vec_t;

  vec_t tv[6];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] t, input logic [15:0] e,
                              input bit nz, input logic [15:0] tr,
                              input logic [15:0] mm, input logic [4:0] ec,
                              input logic [3:0] fi, input logic p,
                              input int dn);
    vec_t v;
    v.tbl = t; v.expv = e; v.noise = nz;
    v.truth = tr; v.mism = mm; v.errc = ec;
    v.fidx = fi; v.pass = p; v.done_at = dn;
    return v;
  endfunction

  // Reference: results straight from the table/expected pair.
  function automatic vec_t model(input logic [15:0] t, input logic [15:0] e,
                                 input bit nz);
    vec_t v;
    logic [15:0] diff;
    int first;
    int mask;
    diff = t ^ e;
    first = -1;
    for (int i = 0; i < 16; i++)
      if (diff[i] && first < 0) first = i;
    v.tbl = t; v.expv = e; v.noise = nz;
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
    if (first >= 0) begin
      mask = (1 << (first + 1)) - 1;
      v.truth = t & mask[15:0];
      mask = 1 << first;
      v.mism = mask[15:0];
      v.errc = 5'd1;
      v.fidx = 4'(first);
      v.pass = 1'b0;
      v.done_at = (first + 1) * VP;
      return v;
    end
`endif
    mask = 0;
    v.truth = t;
    v.mism = diff;
    v.errc = 5'($countones(diff));
    v.fidx = (first < 0) ? 4'd0 : 4'(first);
    v.pass = (diff == 16'h0000);
    v.done_at = 16 * VP + mask;
    return v;
  endfunction

  task automatic run_sweep(input vec_t v, input string tag);
    tbl = v.tbl;
    expected = v.expv;
    noise_on = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expected = 16'($urandom);
    chk({tag, " accept"}, {busy, done, vec}, {1'b1, 1'b0, 4'd0});
    for (int n = 1; n <= v.done_at; n++) begin
      noise_on = v.noise && (n % VP != 0);
      noise_bit = 1'($urandom);
      if (n == 7) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
      if (n < v.done_at)
        chk({tag, " run"}, {busy, done, vec}, {1'b1, 1'b0, 4'(n / VP)});
    end
    noise_on = 1'b0;
    start = 1'b0;
    chk({tag, " done"}, {busy, done}, 2'b01);
    chk({tag, " truth"}, truth, v.truth);
    chk({tag, " mismatch"}, mism, v.mism);
    chk({tag, " err_count"}, errc, v.errc);
    chk({tag, " fail_idx"}, fidx, v.fidx);
    chk({tag, " pass"}, pass, v.pass);
    @(posedge clk); #1;
    chk({tag, " post"}, {busy, done, pass, truth, errc},
        {1'b0, 1'b0, v.pass, v.truth, v.errc});
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    start = 1'b0; expected = 16'h0; tbl = 16'h0;
    noise_on = 1'b0; noise_bit = 1'b0;
    start0 = 1'b0; expected0 = 16'h0; tbl0 = 16'h208E;

    tv[0] = mk(16'h208E, 16'h208E, 0, 16'h208E, 16'h0000, 5'd0, 4'd0, 1, 48);
    tv[5] = mk(16'hA5A5, 16'hA5A5, 1, 16'hA5A5, 16'h0000, 5'd0, 4'd0, 1, 48);
`ifdef LAB3_SWEEP_STOP_ON_FAIL_EN
    tv[1] = mk(16'h208E, 16'h208F, 0, 16'h0000, 16'h0001, 5'd1, 4'd0, 0, 3);
    tv[2] = mk(16'hFFFF, 16'h0000, 0, 16'h0001, 16'h0001, 5'd1, 4'd0, 0, 3);
    tv[3] = mk(16'h208E, 16'h0000, 1, 16'h0002, 16'h0002, 5'd1, 4'd1, 0, 6);
    tv[4] = mk(16'h0000, 16'h8000, 1, 16'h0000, 16'h8000, 5'd1, 4'd15, 0, 48);
`else
    tv[1] = mk(16'h208E, 16'h208F, 0, 16'h208E, 16'h0001, 5'd1, 4'd0, 0, 48);
    tv[2] = mk(16'hFFFF, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 5'd16, 4'd0, 0, 48);
    tv[3] = mk(16'h208E, 16'h0000, 1, 16'h208E, 16'h208E, 5'd5, 4'd1, 0, 48);
    tv[4] = mk(16'h0000, 16'h8000, 1, 16'h0000, 16'h8000, 5'd1, 4'd15, 0, 48);
`endif

    #1;
    chk("reset outputs", {vec, busy, done, pass, truth, mism, errc, fidx}, 0);
    chk("reset outputs0", {vec0, busy0, done0, pass0, truth0, errc0}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle after reset", {busy, done}, 2'b00);

    for (int i = 0; i < 6; i++)
      run_sweep(tv[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic [15:0] t, e;
      t = 16'($urandom);
      e = t;
      if (i % 4 != 0) e = t ^ 16'($urandom & $urandom & $urandom);
      v = model(t, e, 1'($urandom));
      run_sweep(v, $sformatf("rnd%0d", i));
    end

    tbl = 16'h208E;
    expected = 16'h208F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("abort reset", {vec, busy, done, pass, truth, mism, errc, fidx}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("held in reset", {vec, busy, done, truth}, 0);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(tv[0], "after abort");

    tbl = 16'h208E;
    expected = 16'h208E;
    start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      chk($sformatf("held start c%0d", c), {busy, done},
          {((c % 50) <= 47), ((c % 50) == 48)});
      if ((c % 50) == 48)
        chk($sformatf("held result c%0d", c), {pass, truth, mism, errc},
            {1'b1, 16'h208E, 16'h0000, 5'd0});
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("held stopped", {busy, done}, 2'b00);

    expected0 = 16'h208E;
    start0 = 1'b1;
    @(posedge clk); #1;
    chk("s0 accept", {busy0, vec0}, {1'b1, 4'd0});
    for (int n = 1; n <= 16; n++) begin
      start0 = (n == 5);
      @(posedge clk); #1;
      if (n < 16)
        chk($sformatf("s0 step%0d", n), {busy0, done0, vec0},
            {1'b1, 1'b0, 4'(n)});
    end
    start0 = 1'b0;
    chk("s0 done", {busy0, done0, pass0, truth0, mism0, errc0},
        {1'b0, 1'b1, 1'b1, 16'h208E, 16'h0000, 5'd0});
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk($sformatf("s0 after%0d", n), {busy0, done0}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
